fir_seq: RTL and testbench
==========================

FIR_SEQ -- requirements
Module: fir_seq

Interface
REQ-001 Parameter T, default 4, number of taps (T >= 2).
REQ-002 Parameter NI, default 8, sample and coefficient width.
REQ-003 Parameter NO, default 2*NI, output and accumulator width.
REQ-004 Port CLK  input  1  clock; all logic on posedge CLK.
REQ-005 Port RST  input  1  reset, synchronous, active-high.
REQ-006 Port X  input  NI  input sample, unsigned.
REQ-007 Port X_VALID  input  1  sample offered.
REQ-008 Port X_READY  output  1  sample accepted when X_VALID && X_READY.
REQ-009 Port W_WE  input  1  coefficient write strobe.
REQ-010 Port W_ADDR  input  $clog2(T)  coefficient index.
REQ-011 Port W_DATA  input  NI  coefficient value, unsigned.
REQ-012 Port W_READY  output  1  coefficient write honoured when W_WE && W_READY.
REQ-013 Port Y  output  NO  filter result.
REQ-014 Port Y_VALID  output  1  result offered.
REQ-015 Port Y_READY  input  1  result consumed when Y_VALID && Y_READY.
REQ-016 Port BUSY  output  1  high in MAC or OUT state.

Function
REQ-017 Resources: one NI x NI multiplier, one NO-bit accumulator, T-entry coefficient register file W[0..T-1], T-entry sample history H[0..T-1].
REQ-018 FSM states: IDLE, MAC, OUT. IDLE->MAC on sample accept; MAC->OUT after T MAC cycles; OUT->IDLE on result handshake.
REQ-019 X_READY = W_READY = (state == IDLE); BUSY = (state != IDLE); Y_VALID = (state == OUT).
REQ-020 On sample accept, H[0] <= X and H[k] <= H[k-1] for k = 1..T-1; accumulator cleared; tap counter k cleared.
REQ-021 In MAC cycle k (k = 0..T-1), accumulator <= accumulator + W[T-1-k]*H[k]; after k = T-1, state becomes OUT.
REQ-022 Result: Y = sum over k of W[T-1-k]*x[n-k], where x[n] is the newest sample; W[T-1] weights the newest sample and W[0] the oldest.
REQ-023 Arithmetic unsigned; each product is 2*NI bits, zero-extended or truncated to NO bits; the sum wraps modulo 2^NO with no saturation.
REQ-024 Latency: if the sample is accepted in cycle c, Y_VALID rises in cycle c+T+1.
REQ-025 Throughput with Y_READY held high: one sample every T+2 cycles.
REQ-026 In OUT, Y and Y_VALID hold stable until Y_READY; X_VALID is ignored.
REQ-027 A coefficient write is honoured only in IDLE; W_WE in MAC or OUT is dropped with no effect.
REQ-028 Sample accept and coefficient write in the same IDLE cycle: both take effect, and the following MAC uses the new coefficient.
REQ-029 Y is registered and holds the last result while in IDLE and MAC.

Reset
REQ-030 While RST is high at a clock edge, the following take effect at that edge regardless of state (including mid-MAC and in OUT):
- state <= IDLE
- H, W, accumulator, k <= 0
- Y <= 0, so Y_VALID = 0, BUSY = 0, X_READY = 1, W_READY = 1 from the next cycle
REQ-031 Handshakes and writes presented while RST is high are ignored.

Verification (T=4, NI=8, NO=16)
REQ-032 Reset release -> Y=0, Y_VALID=0, X_READY=1, W_READY=1, BUSY=0.
REQ-033 Impulse response:
- stimulus: write W[0..3] = 1,2,3,4; feed samples 1,0,0,0,0 with Y_READY=1
- response: Y = 4,3,2,1,0
- each Y_VALID exactly 5 cycles after its accept.
REQ-034 Backpressure:
- stimulus: Y_READY=0 for 6 cycles during OUT, X_VALID=1 throughout
- response: Y stable, X_READY=0, no extra sample taken
- once Y_READY=1: back to IDLE next cycle.
REQ-035 Write dropped:
- stimulus: W_WE with W_ADDR=3, W_DATA=9 during MAC
- response: W[3] unchanged; next impulse yields 4.
REQ-036 Wrap-around: all W=255, four samples of 255 -> fourth result Y = 4*65025 mod 65536 = 63492.
REQ-037 Mid-MAC reset:
- stimulus: RST at MAC k=2
- response: next cycle state IDLE, Y=0, Y_VALID=0
- subsequent impulse with new coefficients shows no trace of prior history.

Source files
------------

// File: rtl/fir_seq.sv
// Sequential T-tap FIR filter that reuses one multiplier and one accumulator across T MAC cycles.
// Coefficients are written through a simple strobe port while the filter is idle.
module fir_seq #(
    parameter int T  = 4,
    parameter int NI = 8,
    parameter int NO = 2*NI
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic [NI-1:0]        X,
    input  logic                 X_VALID,
    output logic                 X_READY,
    input  logic                 W_WE,
    input  logic [$clog2(T)-1:0] W_ADDR,
    input  logic [NI-1:0]        W_DATA,
    output logic                 W_READY,
    output logic [NO-1:0]        Y,
    output logic                 Y_VALID,
    input  logic                 Y_READY,
    output logic                 BUSY
);
    localparam int KW = $clog2(T);

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t          r_state;
    logic [NI-1:0]   r_h [T];
    logic [NI-1:0]   r_w [T];
    logic [NO-1:0]   r_acc;
    logic [NO-1:0]   r_y;
    logic [KW-1:0]   r_k;

    logic [KW-1:0]   w_widx;
    logic [2*NI-1:0] w_prod;
    logic [NO-1:0]   w_sum;

    // Product is zero-extended or truncated to the accumulator width; the sum wraps.
    function automatic logic [NO-1:0] fit_no(input logic [2*NI-1:0] p);
        return NO'(p);
    endfunction

    // Tap k pairs the k-th newest sample with coefficient T-1-k.
    assign w_widx = KW'(T-1) - r_k;
    assign w_prod = {{NI{1'b0}}, r_w[w_widx]} * {{NI{1'b0}}, r_h[r_k]};
    assign w_sum  = r_acc + fit_no(w_prod);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            for (int i = 0; i < T; i++) begin
                r_h[i] <= '0;
                r_w[i] <= '0;
            end
            r_acc <= '0;
            r_k   <= '0;
            r_y   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (W_WE && (int'(W_ADDR) < T))
                        r_w[W_ADDR] <= W_DATA;
                    if (X_VALID) begin
                        r_h[0] <= X;
                        for (int i = 1; i < T; i++)
                            r_h[i] <= r_h[i-1];
                        r_acc   <= '0;
                        r_k     <= '0;
                        r_state <= MAC;
                    end
                end
                MAC: begin
                    r_acc <= w_sum;
                    if (r_k == KW'(T-1)) begin
                        r_y     <= w_sum;
                        r_state <= OUT;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                OUT: begin
                    if (Y_READY)
                        r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign X_READY = (r_state == IDLE);
    assign W_READY = (r_state == IDLE);
    assign BUSY    = (r_state != IDLE);
    assign Y_VALID = (r_state == OUT);
    assign Y       = r_y;

endmodule

// File: tb/tb_fir_seq.sv
// Directed bench for fir_seq (T=4, NI=8, NO=16): vector table plus hand-written corner sequences.
module tb_fir_seq;
    localparam int T  = 4;
    localparam int NI = 8;
    localparam int NO = 16;

    logic          CLK = 1'b0;
    logic          RST;
    logic [NI-1:0] X;
    logic          X_VALID;
    logic          X_READY;
    logic          W_WE;
    logic [1:0]    W_ADDR;
    logic [NI-1:0] W_DATA;
    logic          W_READY;
    logic [NO-1:0] Y;
    logic          Y_VALID;
    logic          Y_READY;
    logic          BUSY;

    int n_checks = 0;
    int n_fail   = 0;

    fir_seq #(.T(T), .NI(NI), .NO(NO)) dut (
        .CLK(CLK), .RST(RST),
        .X(X), .X_VALID(X_VALID), .X_READY(X_READY),
        .W_WE(W_WE), .W_ADDR(W_ADDR), .W_DATA(W_DATA), .W_READY(W_READY),
        .Y(Y), .Y_VALID(Y_VALID), .Y_READY(Y_READY), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [NI-1:0] x;
        logic [NO-1:0] y;
    } vec_t;

    vec_t tbl [9];

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [NI-1:0] d);
        W_WE = 1'b1; W_ADDR = a; W_DATA = d;
        tick();
        W_WE = 1'b0;
    endtask

    // Offer one sample, wait for the result with Y_READY high, consume it, return in IDLE.
    task automatic send(input logic [NI-1:0] x, input logic we_busy,
                        output logic [NO-1:0] y, output int lat);
        int g = 0;
        Y_READY = 1'b1;
        X = x; X_VALID = 1'b1;
        while (!X_READY && g < 50) begin tick(); g++; end
        if (g >= 50) check("accept_timeout", 0, 1);
        tick();
        X_VALID = 1'b0;
        W_WE = we_busy;
        lat = 1;
        while (!Y_VALID && lat < 50) begin tick(); lat++; end
        if (!Y_VALID) check("yvalid_timeout", 0, 1);
        y = Y;
        W_WE = 1'b0;
        tick();
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [NO-1:0] y;
        int lat;

        // W = 1,2,3,4: impulse, then a short mixed stream.
        tbl[0] = '{x: 8'd1,  y: 16'd4};
        tbl[1] = '{x: 8'd0,  y: 16'd3};
        tbl[2] = '{x: 8'd0,  y: 16'd2};
        tbl[3] = '{x: 8'd0,  y: 16'd1};
        tbl[4] = '{x: 8'd0,  y: 16'd0};
        tbl[5] = '{x: 8'd5,  y: 16'd20};
        tbl[6] = '{x: 8'd10, y: 16'd55};
        tbl[7] = '{x: 8'd7,  y: 16'd68};
        tbl[8] = '{x: 8'd1,  y: 16'd50};

        // Handshakes offered during reset must be ignored.
        RST = 1'b1; X = 8'd9; X_VALID = 1'b1; W_WE = 1'b1; W_ADDR = 2'd0; W_DATA = 8'd77;
        Y_READY = 1'b0;
        repeat (3) tick();
        RST = 1'b0; X_VALID = 1'b0; W_WE = 1'b0;
        tick();
        check("rst_Y", Y, 0);
        check("rst_Y_VALID", Y_VALID, 0);
        check("rst_X_READY", X_READY, 1);
        check("rst_W_READY", W_READY, 1);
        check("rst_BUSY", BUSY, 0);

        wr(2'd0, 8'd1); wr(2'd1, 8'd2); wr(2'd2, 8'd3); wr(2'd3, 8'd4);

        for (int i = 0; i < 9; i++) begin
            send(tbl[i].x, 1'b0, y, lat);
            check($sformatf("vec%0d_Y", i), y, tbl[i].y);
            check($sformatf("vec%0d_latency", i), lat, 5);
        end

        // Backpressure: history now 1,7,10,5 (newest first); sample 2 -> 8+3+14+10 = 35.
        Y_READY = 1'b0; X = 8'd2; X_VALID = 1'b1;
        tick();
        X = 8'd99;
        lat = 1;
        while (!Y_VALID && lat < 50) begin tick(); lat++; end
        check("bp_latency", lat, 5);
        for (int i = 0; i < 6; i++) begin
            check("bp_Y_stable", Y, 35);
            check("bp_X_READY", X_READY, 0);
            check("bp_Y_VALID", Y_VALID, 1);
            tick();
        end
        Y_READY = 1'b1; X_VALID = 1'b0;
        tick();
        check("bp_release_idle", X_READY, 1);
        check("bp_release_BUSY", BUSY, 0);
        // No extra sample taken: history 2,1,7,10 -> sample 0 gives 6+2+7 = 15.
        send(8'd0, 1'b0, y, lat);
        check("bp_no_extra_sample", y, 15);

        // Write during MAC/OUT must be dropped; history 0,0,2,1 -> 5.
        W_ADDR = 2'd3; W_DATA = 8'd9;
        send(8'd0, 1'b1, y, lat);
        check("wdrop_Y", y, 5);
        send(8'd0, 1'b0, y, lat);
        check("wdrop_flush1", y, 2);
        send(8'd0, 1'b0, y, lat);
        check("wdrop_flush2", y, 0);
        send(8'd1, 1'b0, y, lat);
        check("wdrop_impulse", y, 4);

        // Wrap-around: history 1,0,0,0 before the first 255.
        wr(2'd0, 8'd255); wr(2'd1, 8'd255); wr(2'd2, 8'd255); wr(2'd3, 8'd255);
        send(8'd255, 1'b0, y, lat);
        check("wrap_1", y, 65280);
        send(8'd255, 1'b0, y, lat);
        check("wrap_2", y, 64769);
        send(8'd255, 1'b0, y, lat);
        check("wrap_3", y, 64258);
        send(8'd255, 1'b0, y, lat);
        check("wrap_4", y, 63492);

        // Reset at MAC k=2.
        Y_READY = 1'b1; X = 8'd3; X_VALID = 1'b1;
        tick();
        X_VALID = 1'b0;
        tick(); tick();
        check("midmac_BUSY_before", BUSY, 1);
        RST = 1'b1;
        tick();
        check("midmac_BUSY", BUSY, 0);
        check("midmac_Y", Y, 0);
        check("midmac_Y_VALID", Y_VALID, 0);
        check("midmac_X_READY", X_READY, 1);
        RST = 1'b0;
        tick();
        wr(2'd0, 8'd5); wr(2'd1, 8'd6); wr(2'd2, 8'd7); wr(2'd3, 8'd8);
        send(8'd1, 1'b0, y, lat);
        check("post_rst_imp0", y, 8);
        send(8'd0, 1'b0, y, lat);
        check("post_rst_imp1", y, 7);

        // Same-cycle write of W[3]=10 and sample 2: history 2,0,1,0 -> 20+0+6+0 = 26.
        W_WE = 1'b1; W_ADDR = 2'd3; W_DATA = 8'd10;
        send(8'd2, 1'b0, y, lat);
        check("same_cycle_write", y, 26);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
